// File: rtl/io_pkg.sv
// Board-level constants shared by the input conditioning logic.
// The default debounce length is derived from the board clock and the debounce time.
package io_pkg;

  localparam int CLK_HZ                  = 100000000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int BTN_CHANNELS            = 5;
  localparam int SW_CHANNELS             = 16;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } ch_status_t;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit input conditioner: synchroniser, stability counter, stable level, edge pulses.
// The stable level only moves after DEBOUNCE_CYCLES consecutive qualified samples disagree with it.
module debounce_channel
  import io_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_channel: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("debounce_channel: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    // Any sample that agrees with the stable level cancels accumulated progress.
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (sample_en) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
        cnt_d    = '0;
        rise_d   = synced;
        fall_d   = ~synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q    <= '0;
      stable_q <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level_out  = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/io_debouncer.sv
// Multi-channel input conditioner: one debounce_channel per pin plus a combined change flag.
// any_change is an OR of registered pulses, so no path from raw_in reaches an output.
module io_debouncer
  import io_pkg::*;
#(
  parameter int   CHANNELS        = BTN_CHANNELS,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  ch_status_t st [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .raw_in    (raw_in[i]),
      .level_out (st[i].level),
      .rise_pulse(st[i].rise),
      .fall_pulse(st[i].fall)
    );
    assign level_out[i]  = st[i].level;
    assign rise_pulse[i] = st[i].rise;
    assign fall_pulse[i] = st[i].fall;
  end

  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_io_debouncer.sv
// Scoreboard bench for io_debouncer with 3 channels, 2 sync stages, 4-sample debounce.
module tb_io_debouncer;

  localparam int CH  = 3;
  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int LAT = SS + DC;  // stimulus applied at cyc=c, pulse observed at cyc=c+LAT

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [CH-1:0] raw_in;
  logic [CH-1:0] level_out, rise_pulse, fall_pulse;
  logic          any_change;

  io_debouncer #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [CH-1:0] lvl;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } ev_t;

  ev_t           q[$];
  logic [CH-1:0] exp_level = '0;
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            presc   = 1'b0;

  // One cycle: advance to the falling edge, check outputs against the scoreboard, drive sample_en.
  task automatic tick();
    ev_t ev;
    @(negedge clk);
    if (!rst) exp_level = '0;
    if (rise_pulse !== '0 || fall_pulse !== '0) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b required none", cyc, rise_pulse, fall_pulse);
      end else begin
        ev = q.pop_front();
        if (cyc !== ev.cyc || rise_pulse !== ev.rise || fall_pulse !== ev.fall ||
            level_out !== ev.lvl || any_change !== 1'b1) begin
          n_fail++;
          $display("FAIL pulse_event got cyc=%0d rise=%b fall=%b level=%b any=%b required cyc=%0d rise=%b fall=%b level=%b any=1",
                   cyc, rise_pulse, fall_pulse, level_out, any_change, ev.cyc, ev.rise, ev.fall, ev.lvl);
        end
        exp_level = ev.lvl;
      end
    end else begin
      n_tests++;
      if (level_out !== exp_level || any_change !== 1'b0) begin
        n_fail++;
        $display("FAIL level_hold cyc=%0d level=%b any=%b required level=%b any=0",
                 cyc, level_out, any_change, exp_level);
      end
    end
    sample_en = presc ? ((cyc % 4) == 0) : 1'b1;
  endtask

  task automatic expect_ev(input int c, input logic [CH-1:0] lvl, input logic [CH-1:0] r,
                           input logic [CH-1:0] f);
    ev_t ev;
    ev.cyc = c; ev.lvl = lvl; ev.rise = r; ev.fall = f;
    q.push_back(ev);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 60) begin
      tick();
      t++;
    end
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout pending=%0d required 0", name, q.size());
      q.delete();
    end
    repeat (8) tick();
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b0; raw_in = 3'b111; sample_en = 1'b1; presc = 1'b0;
    repeat (8) begin
      tick();
      n_tests++;
      if (level_out !== 3'b000 || rise_pulse !== 3'b000 || fall_pulse !== 3'b000 || any_change !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold level=%b rise=%b fall=%b any=%b required 000/000/000/0",
                 level_out, rise_pulse, fall_pulse, any_change);
      end
    end
    tick();
    rst = 1'b1; c = cyc;
    expect_ev(c + LAT, 3'b111, 3'b111, 3'b000);
    drain("reset_release");
  endtask

  task automatic test_fall_simultaneous();
    int c;
    tick();
    raw_in = 3'b010; c = cyc;
    expect_ev(c + LAT, 3'b010, 3'b000, 3'b101);
    drain("fall_simul");
  endtask

  task automatic test_clean_step();
    int c;
    tick();
    raw_in[0] = 1'b1; c = cyc;
    expect_ev(c + LAT, 3'b011, 3'b001, 3'b000);
    drain("clean_step");
  endtask

  task automatic test_bounce();
    int c;
    tick();
    raw_in[1] = 1'b0; c = cyc;
    expect_ev(c + LAT, 3'b001, 3'b000, 3'b010);
    drain("bounce_setup");
    tick(); raw_in[1] = 1'b1;
    tick(); raw_in[1] = 1'b0;
    tick(); raw_in[1] = 1'b1;
    tick(); raw_in[1] = 1'b0;
    tick(); raw_in[1] = 1'b1; c = cyc;
    expect_ev(c + LAT, 3'b011, 3'b010, 3'b000);
    drain("bounce");
  endtask

  task automatic test_prescaler();
    int c, k, cnt, e;
    presc = 1'b1;
    tick();
    raw_in[2] = 1'b1; c = cyc;
    cnt = 0; k = SS; e = -1;
    while (e < 0) begin
      if (((c + k) % 4) == 0) begin
        cnt++;
        if (cnt == DC) e = c + k + 1;
      end
      k++;
    end
    expect_ev(e, 3'b111, 3'b100, 3'b000);
    drain("prescaler");
    presc = 1'b0;
  endtask

  task automatic test_reset_midcount();
    int c;
    tick();
    raw_in[0] = 1'b0; c = cyc;
    expect_ev(c + LAT, 3'b110, 3'b000, 3'b001);
    drain("mid_setup");
    tick();
    raw_in[0] = 1'b1;
    repeat (4) tick();
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (level_out !== 3'b000 || rise_pulse !== 3'b000 || fall_pulse !== 3'b000 || any_change !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_clear level=%b rise=%b fall=%b any=%b required 000/000/000/0",
               level_out, rise_pulse, fall_pulse, any_change);
    end
    repeat (3) tick();
    tick();
    rst = 1'b1; c = cyc;
    expect_ev(c + LAT, 3'b111, 3'b111, 3'b000);
    drain("midcount_release");
  endtask

  initial begin
    test_reset();
    test_fall_simultaneous();
    test_clean_step();
    test_bounce();
    test_prescaler();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
